// File: rtl/perf_counter_bank_pkg.sv
// Purpose: shared register map, limits and decode types for the performance-counter bank.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package perf_counter_bank_pkg;

  localparam int CNT_MAX_NUM = 8;

  // IO register offsets (0x04..0x06 keep the legacy map)
  localparam int PCB_ADR_CYCLE   = 'h04;
  localparam int PCB_ADR_INSTRET = 'h05;
  localparam int PCB_ADR_CLR_ALL = 'h06;
  localparam int PCB_ADR_EN      = 'h07;
  localparam int PCB_ADR_CLR     = 'h08;
  localparam int PCB_ADR_SNAP    = 'h09;
  localparam int PCB_ADR_OVF     = 'h0A;
  localparam int PCB_ADR_LIVE    = 'h10;
  localparam int PCB_ADR_SNAP_RD = 'h18;

  // One-hot-ish decode of a bus write; at most one field is set per cycle
  typedef struct packed {
    logic clr_all;
    logic en;
    logic clr_mask;
    logic snap;
    logic ovf_w1c;
  } pcb_wr_t;

  // Any nonzero byte enable marks the access as a write
  function automatic logic is_write(input logic [3:0] wea);
    return |wea;
  endfunction

endpackage

// File: rtl/perf_counter_bank_counter.sv
// Purpose: one event counter with clear, snapshot register and overflow detection.
// Latency: count/clear/snapshot visible one clock after the strobe.
// Backpressure: none; strobes are accepted every cycle.
// Ports: clk, rst (sync, active-high), inc (gated event), clr, snap, snap_clr,
//        cnt (live value), snap_val (captured value), ovf_pulse (combinational).
module perf_counter_bank_counter #(
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic                 snap,
  input  logic                 snap_clr,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic [CNT_WIDTH-1:0] snap_val,
  output logic                 ovf_pulse
);

  localparam logic [CNT_WIDTH-1:0] CNT_ALL_ONES = '1;

  logic at_max;
  assign at_max = (cnt == CNT_ALL_ONES);

  // A clear in the same cycle suppresses the increment, so it cannot overflow either
  assign ovf_pulse = inc & ~clr & at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (at_max) cnt <= SATURATE ? CNT_ALL_ONES : '0;
      else        cnt <= cnt + 1'b1;
    end
  end

  // Captures the pre-increment / pre-clear value because cnt is read before its update
  always_ff @(posedge clk) begin
    if (rst)           snap_val <= '0;
    else if (snap_clr) snap_val <= '0;
    else if (snap)     snap_val <= cnt;
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Purpose: memory-mapped bank of NUM_CNT event counters with enable, masked clear, snapshot, sticky overflow.
// Latency: read data registered, valid one clock after the read cycle; writes take effect next clock.
// Backpressure: none; every IO access completes in one cycle.
// Ports: clk, cpu_rst (sync, active-high), io_en/wea/adr/din_io (IO bus request),
//        evt (per-counter increment strobes), dout_io (registered read data).
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADR_WIDTH = 5,
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 32,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 cpu_rst,
  input  logic                 io_en,
  input  logic [3:0]           wea,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [XLEN-1:0]      din_io,
  input  logic [NUM_CNT-1:0]   evt,
  output logic [XLEN-1:0]      dout_io
);

  logic                 bus_wr;
  logic                 bus_rd;
  pcb_wr_t              wr;
  logic [NUM_CNT-1:0]   en_q;
  logic [NUM_CNT-1:0]   ovf_q;
  logic [NUM_CNT-1:0]   ovf_pulse;
  logic [NUM_CNT-1:0]   w1c_mask;
  logic [CNT_WIDTH-1:0] cnt_val  [NUM_CNT];
  logic [CNT_WIDTH-1:0] snap_val [NUM_CNT];
  logic [XLEN-1:0]      rd_data;
  logic                 unused_din;

  // Upper write-data bits carry no meaning for EN/CLR/OVF
  assign unused_din = ^din_io[XLEN-1:NUM_CNT];

  assign bus_wr = io_en &  is_write(wea);
  assign bus_rd = io_en & ~is_write(wea);

  always_comb begin
    wr = '0;
    if (bus_wr) begin
      wr.clr_all  = (adr == ADR_WIDTH'(PCB_ADR_CLR_ALL));
      wr.en       = (adr == ADR_WIDTH'(PCB_ADR_EN));
      wr.clr_mask = (adr == ADR_WIDTH'(PCB_ADR_CLR));
      wr.snap     = (adr == ADR_WIDTH'(PCB_ADR_SNAP));
      wr.ovf_w1c  = (adr == ADR_WIDTH'(PCB_ADR_OVF));
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    perf_counter_bank_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SATURATE  (SATURATE)
    ) u_cnt (
      .clk       (clk),
      .rst       (cpu_rst),
      .inc       (en_q[g] & evt[g]),
      .clr       (wr.clr_all | (wr.clr_mask & din_io[g])),
      .snap      (wr.snap),
      .snap_clr  (wr.clr_all),
      .cnt       (cnt_val[g]),
      .snap_val  (snap_val[g]),
      .ovf_pulse (ovf_pulse[g])
    );
  end

  // Enables come up all ones so counting starts straight out of reset
  always_ff @(posedge clk) begin
    if (cpu_rst)     en_q <= '1;
    else if (wr.en)  en_q <= din_io[NUM_CNT-1:0];
  end

  assign w1c_mask = wr.ovf_w1c ? din_io[NUM_CNT-1:0] : '0;

  // A fresh overflow in the W1C cycle is OR-ed in after the clear, so it survives
  always_ff @(posedge clk) begin
    if (cpu_rst)         ovf_q <= '0;
    else if (wr.clr_all) ovf_q <= '0;
    else                 ovf_q <= (ovf_q & ~w1c_mask) | ovf_pulse;
  end

  always_comb begin
    rd_data = '0;
    if (adr == ADR_WIDTH'(PCB_ADR_CYCLE))   rd_data = XLEN'(cnt_val[0]);
    if (adr == ADR_WIDTH'(PCB_ADR_INSTRET)) rd_data = XLEN'(cnt_val[1]);
    if (adr == ADR_WIDTH'(PCB_ADR_EN))      rd_data = XLEN'(en_q);
    if (adr == ADR_WIDTH'(PCB_ADR_OVF))     rd_data = XLEN'(ovf_q);
    for (int i = 0; i < NUM_CNT; i++) begin
      if (adr == ADR_WIDTH'(PCB_ADR_LIVE + i))    rd_data = XLEN'(cnt_val[i]);
      if (adr == ADR_WIDTH'(PCB_ADR_SNAP_RD + i)) rd_data = XLEN'(snap_val[i]);
    end
  end

  // Holds the last read value across writes and idle cycles
  always_ff @(posedge clk) begin
    if (cpu_rst)     dout_io <= '0;
    else if (bus_rd) dout_io <= rd_data;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        io_en;
  logic [3:0]  wea;
  logic [4:0]  adr;
  logic [31:0] din_io;
  logic [3:0]  evt;
  logic [31:0] dout_a, dout_w, dout_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // a: default 32-bit wrap; w: 4-bit wrap; s: 4-bit saturate. All share the bus.
  perf_counter_bank u_a (
    .clk(clk), .cpu_rst(cpu_rst), .io_en(io_en), .wea(wea), .adr(adr),
    .din_io(din_io), .evt(evt), .dout_io(dout_a));
  perf_counter_bank #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_w (
    .clk(clk), .cpu_rst(cpu_rst), .io_en(io_en), .wea(wea), .adr(adr),
    .din_io(din_io), .evt(evt), .dout_io(dout_w));
  perf_counter_bank #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_s (
    .clk(clk), .cpu_rst(cpu_rst), .io_en(io_en), .wea(wea), .adr(adr),
    .din_io(din_io), .evt(evt), .dout_io(dout_s));

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    io_en = 1'b1; wea = 4'hF; adr = a; din_io = d;
    tick(1);
    io_en = 1'b0; wea = 4'h0; din_io = '0;
  endtask

  task automatic bus_rd(input logic [4:0] a);
    io_en = 1'b1; wea = 4'h0; adr = a;
    tick(1);
    io_en = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; io_en = 1'b0; wea = '0; adr = '0; din_io = '0; evt = '0;
    tick(2);
    total++; if (dout_a !== 32'd0) $display("FAIL reset_dout: got %0h want 0", dout_a); else passed++;
    cpu_rst = 1'b0;
    bus_rd(5'h07);
    total++; if (dout_a !== 32'hF) $display("FAIL reset_en: got %0h want f", dout_a); else passed++;
    bus_rd(5'h0A);
    total++; if (dout_a !== 32'h0) $display("FAIL reset_ovf: got %0h want 0", dout_a); else passed++;
  endtask

  task automatic test_count();
    evt = 4'b0011;
    tick(10);
    evt = 4'b0000;
    bus_rd(5'h04);
    total++; if (dout_a !== 32'd10) $display("FAIL cycle_cnt: got %0d want 10", dout_a); else passed++;
    bus_rd(5'h05);
    total++; if (dout_a !== 32'd10) $display("FAIL instret_cnt: got %0d want 10", dout_a); else passed++;
    bus_wr(5'h02, 32'h1234);
    total++; if (dout_a !== 32'd10) $display("FAIL dout_hold_on_write: got %0d want 10", dout_a); else passed++;
    bus_rd(5'h12);
    total++; if (dout_a !== 32'd0) $display("FAIL idle_cnt2: got %0d want 0", dout_a); else passed++;
  endtask

  task automatic test_enable_clear();
    // cnt0=10, cnt1=10. The EN write cycle still counts with the old EN.
    evt = 4'b0011;
    bus_wr(5'h07, 32'hFFFF_FFF1);
    tick(7);
    evt = 4'b0000;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd18) $display("FAIL en_cnt0: got %0d want 18", dout_a); else passed++;
    bus_rd(5'h11);
    total++; if (dout_a !== 32'd11) $display("FAIL en_cnt1: got %0d want 11", dout_a); else passed++;
    bus_rd(5'h07);
    total++; if (dout_a !== 32'h1) $display("FAIL en_readback: got %0h want 1", dout_a); else passed++;
    evt = 4'b0001;
    bus_wr(5'h08, 32'h1);
    evt = 4'b0000;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd0) $display("FAIL clr_beats_inc: got %0d want 0", dout_a); else passed++;
    bus_rd(5'h11);
    total++; if (dout_a !== 32'd11) $display("FAIL clr_mask_other: got %0d want 11", dout_a); else passed++;
    bus_wr(5'h07, 32'hF);
  endtask

  task automatic test_snapshot();
    bus_wr(5'h06, 32'h0);
    evt = 4'b0001;
    tick(100);
    bus_wr(5'h09, 32'h0);   // cnt0 is 100 entering this cycle
    bus_rd(5'h18);
    total++; if (dout_a !== 32'd100) $display("FAIL snap_val: got %0d want 100", dout_a); else passed++;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd102) $display("FAIL snap_live: got %0d want 102", dout_a); else passed++;
    evt = 4'b0000;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd103) $display("FAIL live_after_stop: got %0d want 103", dout_a); else passed++;
    bus_rd(5'h18);
    total++; if (dout_a !== 32'd100) $display("FAIL snap_stable: got %0d want 100", dout_a); else passed++;
  endtask

  task automatic test_overflow();
    bus_wr(5'h06, 32'h0);
    evt = 4'b0001;
    tick(16);
    evt = 4'b0000;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd16) $display("FAIL ovf_cnt_wide: got %0d want 16", dout_a); else passed++;
    total++; if (dout_w !== 32'd0)  $display("FAIL ovf_cnt_wrap: got %0d want 0", dout_w); else passed++;
    total++; if (dout_s !== 32'd15) $display("FAIL ovf_cnt_sat: got %0d want 15", dout_s); else passed++;
    bus_rd(5'h0A);
    total++; if (dout_a !== 32'h0) $display("FAIL ovf_flag_wide: got %0h want 0", dout_a); else passed++;
    total++; if (dout_w !== 32'h1) $display("FAIL ovf_flag_wrap: got %0h want 1", dout_w); else passed++;
    total++; if (dout_s !== 32'h1) $display("FAIL ovf_flag_sat: got %0h want 1", dout_s); else passed++;
    // W1C while counting: saturating counter overflows again in the same cycle
    evt = 4'b0001;
    bus_wr(5'h0A, 32'h1);
    evt = 4'b0000;
    bus_rd(5'h0A);
    total++; if (dout_w !== 32'h0) $display("FAIL w1c_wrap: got %0h want 0", dout_w); else passed++;
    total++; if (dout_s !== 32'h1) $display("FAIL w1c_new_ovf_wins: got %0h want 1", dout_s); else passed++;
    bus_rd(5'h10);
    total++; if (dout_w !== 32'd1)  $display("FAIL wrap_resumes: got %0d want 1", dout_w); else passed++;
    total++; if (dout_s !== 32'd15) $display("FAIL sat_holds: got %0d want 15", dout_s); else passed++;
    bus_wr(5'h0A, 32'hFFFF_FFFE);
    bus_rd(5'h0A);
    total++; if (dout_s !== 32'h1) $display("FAIL w1c_zero_bit: got %0h want 1", dout_s); else passed++;
    bus_wr(5'h0A, 32'h1);
    bus_rd(5'h0A);
    total++; if (dout_s !== 32'h0) $display("FAIL w1c_sat: got %0h want 0", dout_s); else passed++;
  endtask

  task automatic test_clear_all();
    evt = 4'b0011;
    tick(10);
    bus_wr(5'h09, 32'h0);
    tick(9);
    bus_wr(5'h06, 32'h0);
    evt = 4'b0000;
    bus_rd(5'h10);
    total++; if (dout_a !== 32'd0) $display("FAIL clrall_cnt0: got %0d want 0", dout_a); else passed++;
    bus_rd(5'h11);
    total++; if (dout_a !== 32'd0) $display("FAIL clrall_cnt1: got %0d want 0", dout_a); else passed++;
    bus_rd(5'h18);
    total++; if (dout_a !== 32'd0) $display("FAIL clrall_snap: got %0d want 0", dout_a); else passed++;
    bus_rd(5'h0A);
    total++; if (dout_w !== 32'h0) $display("FAIL clrall_ovf: got %0h want 0", dout_w); else passed++;
    evt = 4'b0001;
    tick(3);
    evt = 4'b0000;
    bus_wr(5'h04, 32'h55);
    bus_wr(5'h02, 32'hFF);
    bus_rd(5'h04);
    total++; if (dout_a !== 32'd3) $display("FAIL ro_write_ignored: got %0d want 3", dout_a); else passed++;
    bus_rd(5'h1F);
    total++; if (dout_a !== 32'd0) $display("FAIL unmapped_1f: got %0d want 0", dout_a); else passed++;
  endtask

  task automatic test_reset_midrun();
    bus_wr(5'h07, 32'h2);
    evt = 4'b0011;
    tick(5);
    bus_rd(5'h11);
    total++; if (dout_a !== 32'd5) $display("FAIL pre_rst_cnt1: got %0d want 5", dout_a); else passed++;
    io_en = 1'b1; wea = 4'h0; adr = 5'h11; cpu_rst = 1'b1;
    tick(1);
    io_en = 1'b0; cpu_rst = 1'b0;
    total++; if (dout_a !== 32'd0) $display("FAIL rst_drops_read: got %0d want 0", dout_a); else passed++;
    tick(6);
    evt = 4'b0000;
    bus_rd(5'h04);
    total++; if (dout_a !== 32'd6) $display("FAIL rst_restart_cnt0: got %0d want 6", dout_a); else passed++;
    bus_rd(5'h05);
    total++; if (dout_a !== 32'd6) $display("FAIL rst_restart_cnt1: got %0d want 6", dout_a); else passed++;
    bus_rd(5'h07);
    total++; if (dout_a !== 32'hF) $display("FAIL rst_en_ones: got %0h want f", dout_a); else passed++;
  endtask

  initial begin
    test_reset();
    test_count();
    test_enable_clear();
    test_snapshot();
    test_overflow();
    test_clear_all();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
